dmem_arbiter: RTL and testbench

Arbitrates the single data-memory port of the MEM stage between the pipeline and the debug unit. Pipeline loads and stores always win. When the pipeline leaves the port idle, a debug-initiated dump walks the whole data memory as LW reads. Each word goes to the debug unit over a valid/ready handshake. The block sits between the EX/MEM pipeline register, the UART debug unit and the MEM stage.

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/dump_word_counter.sv | 32 +++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data port: access-size codes,
// dump FSM encoding and the dump length derived from memory size.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        BHW_LB  = 3'b000,
        BHW_LH  = 3'b001,
        BHW_LW  = 3'b011,
        BHW_LBU = 3'b100,
        BHW_LHU = 3'b101,
        BHW_LWU = 3'b111
    } bhw_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_OUT   = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_t;

    // One dump covers every 32-bit word of a byte-addressed memory.
    function automatic int dump_words(input int nb_addr);
        return (1 << nb_addr) / 4;
    endfunction

endpackage

// File: rtl/dump_word_counter.sv
// Word counter and byte-address register for a memory dump; the address
// advances by one word per increment and `last` marks the final word.
module dump_word_counter #(
    parameter  int NB_ADDR    = 9,
    parameter  int DUMP_WORDS = 128,
    localparam int NB_CNT     = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               clear,
    input  logic               incr,
    output logic [NB_ADDR-1:0] addr,
    output logic               last
);

    localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(DUMP_WORDS - 1);

    logic [NB_CNT-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset || clear) begin
            count <= '0;
            addr  <= '0;
        end else if (incr) begin
            count <= count + NB_CNT'(1);
            addr  <= addr + NB_ADDR'(4);
        end
    end

    assign last = (count == LAST_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the MEM-stage data port between the pipeline and a debug memory
// dump; the pipeline always has priority and the dump only uses idle cycles.
module dmem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int NB_WIDTH   = 32,
    parameter int NB_ADDR    = 9,
    parameter int DUMP_WORDS = dump_words(NB_ADDR)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_WIDTH-1:0] i_pipe_addr,
    input  logic [NB_WIDTH-1:0] i_pipe_wdata,
    input  logic                i_pipe_read,
    input  logic                i_pipe_write,
    input  logic [2:0]          i_pipe_bhw,
    input  logic                i_dbg_start,
    input  logic                i_dbg_halted,
    input  logic                i_dbg_ready,
    output logic [NB_WIDTH-1:0] o_dbg_word,
    output logic [NB_ADDR-1:0]  o_dbg_addr,
    output logic                o_dbg_valid,
    output logic                o_dbg_busy,
    output logic                o_dbg_done,
    output logic [NB_WIDTH-1:0] o_mem_addr,
    output logic [NB_WIDTH-1:0] o_mem_data,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic [2:0]          o_mem_bhw,
    input  logic [NB_WIDTH-1:0] i_mem_rdata
);

    dump_state_t        state, state_next;
    logic               pipe_req;
    logic               cnt_clear;
    logic               cnt_incr;
    logic               capture;
    logic               last_word;
    logic [NB_ADDR-1:0] dump_addr;

    assign pipe_req = i_pipe_read | i_pipe_write;

    dump_word_counter #(
        .NB_ADDR    (NB_ADDR),
        .DUMP_WORDS (DUMP_WORDS)
    ) u_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .clear   (cnt_clear),
        .incr    (cnt_incr),
        .addr    (dump_addr),
        .last    (last_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_dbg_start && i_dbg_halted) state_next = ST_ISSUE;
            ST_ISSUE: if (!pipe_req)                   state_next = ST_OUT;
            ST_OUT:   if (i_dbg_ready)                 state_next = last_word ? ST_DONE : ST_ISSUE;
            ST_DONE:                                   state_next = ST_IDLE;
            default:                                   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_clear   = (state == ST_IDLE) && i_dbg_start && i_dbg_halted;
        capture     = (state == ST_ISSUE) && !pipe_req;
        cnt_incr    = (state == ST_OUT) && i_dbg_ready && !last_word;
        o_dbg_valid = (state == ST_OUT);
        o_dbg_done  = (state == ST_DONE);
        o_dbg_busy  = (state != ST_IDLE);
    end

    // MEM drives read data at the negedge, so it is already valid here.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_dbg_word <= '0;
            o_dbg_addr <= '0;
        end else if (capture) begin
            o_dbg_word <= i_mem_rdata;
            o_dbg_addr <= dump_addr;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_data  = '0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        o_mem_bhw   = 3'b000;
        if (pipe_req) begin
            o_mem_addr  = i_pipe_addr;
            o_mem_data  = i_pipe_wdata;
            o_mem_read  = i_pipe_read;
            o_mem_write = i_pipe_write;
            o_mem_bhw   = i_pipe_bhw;
        end else if (state == ST_ISSUE) begin
            o_mem_addr  = NB_WIDTH'(dump_addr);
            o_mem_read  = 1'b1;
            o_mem_bhw   = BHW_LW;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small data-memory model that
// returns read data at the negedge and commits stores at the posedge.
module tb_dmem_arbiter;
    import mips_mem_pkg::*;

    localparam int NB_WIDTH   = 32;
    localparam int NB_ADDR    = 9;
    localparam int DUMP_WORDS = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pipe_addr, pipe_wdata;
    logic        pipe_read, pipe_write;
    logic [2:0]  pipe_bhw;
    logic        dbg_start, dbg_halted, dbg_ready;
    logic [31:0] dbg_word;
    logic [8:0]  dbg_addr;
    logic        dbg_valid, dbg_busy, dbg_done;
    logic [31:0] mem_addr, mem_data;
    logic        mem_read, mem_write;
    logic [2:0]  mem_bhw;
    logic [31:0] mem_rdata;

    logic [31:0] mem  [DUMP_WORDS];
    logic [31:0] expw [DUMP_WORDS];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NB_WIDTH   (NB_WIDTH),
        .NB_ADDR    (NB_ADDR),
        .DUMP_WORDS (DUMP_WORDS)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_pipe_addr  (pipe_addr),
        .i_pipe_wdata (pipe_wdata),
        .i_pipe_read  (pipe_read),
        .i_pipe_write (pipe_write),
        .i_pipe_bhw   (pipe_bhw),
        .i_dbg_start  (dbg_start),
        .i_dbg_halted (dbg_halted),
        .i_dbg_ready  (dbg_ready),
        .o_dbg_word   (dbg_word),
        .o_dbg_addr   (dbg_addr),
        .o_dbg_valid  (dbg_valid),
        .o_dbg_busy   (dbg_busy),
        .o_dbg_done   (dbg_done),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_data),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_mem_bhw    (mem_bhw),
        .i_mem_rdata  (mem_rdata)
    );

    always @(negedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr[8:2]];
    end

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[8:2]] <= mem_data;
    end

    // Runs one dump with ready high except for an optional stall; start may be
    // re-pulsed mid-dump. Results are returned for the caller to judge.
    task automatic collect_dump(input bit do_start, input int stall_word, input int stall_len,
                                input bit pulse_busy_start, output int beats, output int cycles,
                                output int bad, output bit saw_done, output logic [31:0] word16);
        int          stalled;
        logic [31:0] held_w;
        logic [8:0]  held_a;
        beats = 0; cycles = 0; bad = 0; stalled = 0; saw_done = 0; word16 = '0;
        held_w = '0; held_a = '0;
        if (do_start) begin
            dbg_halted = 1'b1; dbg_start = 1'b1;
            @(posedge clk); #1;
            dbg_start = 1'b0;
        end
        cycles = 1;
        while (!saw_done && cycles < 2000) begin
            dbg_start = 1'b0;
            if (dbg_done) begin
                saw_done = 1'b1;
            end else begin
                if (dbg_valid && beats == stall_word && stalled < stall_len) begin
                    if (stalled == 0) begin
                        held_w = dbg_word; held_a = dbg_addr;
                    end else if (dbg_word !== held_w || dbg_addr !== held_a) begin
                        bad++;
                    end
                    stalled++;
                    dbg_ready = 1'b0;
                end else begin
                    dbg_ready = 1'b1;
                    if (dbg_valid) begin
                        if (beats >= DUMP_WORDS) bad++;
                        else if (dbg_addr !== 9'(4 * beats) || dbg_word !== expw[beats]) bad++;
                        if (dbg_addr == 9'd16) word16 = dbg_word;
                        beats++;
                    end
                end
                if (pulse_busy_start && beats == 5) dbg_start = 1'b1;
                @(posedge clk); #1;
                cycles++;
            end
        end
        dbg_ready = 1'b0;
        dbg_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dbg_valid, dbg_busy, dbg_done} !== 3'b000 || dbg_word !== 32'h0 || dbg_addr !== 9'h0)
            begin errors++; $display("[TB] FAIL reset_dbg: valid/busy/done=%b word=%h addr=%h, need 000/0/0",
                                     {dbg_valid, dbg_busy, dbg_done}, dbg_word, dbg_addr); end
        checks++;
        if ({mem_addr, mem_data, mem_read, mem_write, mem_bhw} !== 69'h0)
            begin errors++; $display("[TB] FAIL reset_mem: addr=%h data=%h rd=%b wr=%b bhw=%b, need all 0",
                                     mem_addr, mem_data, mem_read, mem_write, mem_bhw); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pipe_passthrough();
        pipe_addr = 32'h0000_0123; pipe_wdata = 32'h0BAD_F00D; pipe_read = 1'b1; pipe_bhw = BHW_LB;
        #1;
        checks++;
        if ({mem_addr, mem_data, mem_read, mem_write, mem_bhw} !== {32'h0000_0123, 32'h0BAD_F00D, 1'b1, 1'b0, 3'b000})
            begin errors++; $display("[TB] FAIL pipe_lb: addr=%h data=%h rd=%b wr=%b bhw=%b, need 123/0badf00d/1/0/000",
                                     mem_addr, mem_data, mem_read, mem_write, mem_bhw); end
        pipe_addr = 32'h0000_01FE; pipe_wdata = 32'h1234_5678; pipe_bhw = BHW_LHU;
        #1;
        checks++;
        if ({mem_addr, mem_data, mem_read, mem_write, mem_bhw} !== {32'h0000_01FE, 32'h1234_5678, 1'b1, 1'b0, 3'b101})
            begin errors++; $display("[TB] FAIL pipe_lhu: addr=%h data=%h rd=%b wr=%b bhw=%b, need 1fe/12345678/1/0/101",
                                     mem_addr, mem_data, mem_read, mem_write, mem_bhw); end
        pipe_read = 1'b0; pipe_addr = '0; pipe_wdata = '0; pipe_bhw = 3'b000;
        #1;
        checks++;
        if ({mem_read, mem_write, mem_addr} !== 34'h0)
            begin errors++; $display("[TB] FAIL idle_port: rd=%b wr=%b addr=%h, need 0/0/0", mem_read, mem_write, mem_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_dump();
        int beats, cycles, bad; bit saw_done; logic [31:0] w16;
        collect_dump(1'b1, -1, 0, 1'b0, beats, cycles, bad, saw_done, w16);
        checks++;
        if (!saw_done) begin errors++; $display("[TB] FAIL full_done_seen: done=0 after %0d cycles, need done", cycles); end
        checks++;
        if (beats != 128) begin errors++; $display("[TB] FAIL full_beats: got %0d, need 128", beats); end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL full_data: %0d bad beats, need 0", bad); end
        checks++;
        if (cycles != 257) begin errors++; $display("[TB] FAIL full_latency: done at cycle %0d, need 257", cycles); end
        @(posedge clk); #1;
        checks++;
        if ({dbg_done, dbg_busy} !== 2'b00) begin errors++;
            $display("[TB] FAIL done_pulse: done/busy=%b one cycle later, need 00", {dbg_done, dbg_busy}); end
    endtask

    task automatic test_backpressure();
        int beats, cycles, bad; bit saw_done; logic [31:0] w16;
        collect_dump(1'b1, 3, 5, 1'b0, beats, cycles, bad, saw_done, w16);
        checks++;
        if (beats != 128 || bad != 0) begin errors++;
            $display("[TB] FAIL bp_beats: beats=%0d bad=%0d, need 128/0", beats, bad); end
        checks++;
        if (!saw_done || cycles != 262) begin errors++;
            $display("[TB] FAIL bp_latency: done=%b at cycle %0d, need 1 at 262", saw_done, cycles); end
        @(posedge clk); #1;
    endtask

    task automatic test_conflict();
        int beats, cycles, bad; bit saw_done; logic [31:0] w16;
        expw[4] = 32'hDEAD_BEEF;
        dbg_halted = 1'b1; dbg_start = 1'b1;
        @(posedge clk); #1;
        dbg_start = 1'b0;
        pipe_write = 1'b1; pipe_addr = 32'h10; pipe_wdata = 32'hDEAD_BEEF; pipe_bhw = BHW_LW;
        #1;
        checks++;
        if ({mem_addr, mem_data, mem_read, mem_write, mem_bhw} !== {32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b011})
            begin errors++; $display("[TB] FAIL conflict_pipe: addr=%h data=%h rd=%b wr=%b bhw=%b, need 10/deadbeef/0/1/011",
                                     mem_addr, mem_data, mem_read, mem_write, mem_bhw); end
        @(posedge clk); #1;
        pipe_write = 1'b0; pipe_addr = '0; pipe_wdata = '0; pipe_bhw = 3'b000;
        #1;
        checks++;
        if ({dbg_valid, dbg_busy, mem_read, mem_write, mem_bhw} !== {1'b0, 1'b1, 1'b1, 1'b0, 3'b011} || mem_addr !== 32'h0)
            begin errors++; $display("[TB] FAIL conflict_stall: valid=%b busy=%b rd=%b addr=%h bhw=%b, need 0/1/1/0/011",
                                     dbg_valid, dbg_busy, mem_read, mem_addr, mem_bhw); end
        @(posedge clk); #1;
        checks++;
        if (dbg_valid !== 1'b1 || dbg_word !== 32'hA500_0000 || dbg_addr !== 9'd0)
            begin errors++; $display("[TB] FAIL conflict_resume: valid=%b word=%h addr=%h, need 1/a5000000/0",
                                     dbg_valid, dbg_word, dbg_addr); end
        collect_dump(1'b0, -1, 0, 1'b0, beats, cycles, bad, saw_done, w16);
        checks++;
        if (w16 !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL conflict_word16: got %h, need deadbeef", w16); end
        checks++;
        if (beats != 128 || bad != 0 || !saw_done) begin errors++;
            $display("[TB] FAIL conflict_dump: beats=%0d bad=%0d done=%b, need 128/0/1", beats, bad, saw_done); end
        mem[4] <= 32'hA500_0004;
        expw[4] = 32'hA500_0004;
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        int beats, cycles, bad; bit saw_done; logic [31:0] w16;
        dbg_halted = 1'b0; dbg_start = 1'b1;
        @(posedge clk); #1;
        dbg_start = 1'b0;
        repeat (3) begin
            checks++;
            if ({dbg_busy, dbg_valid, mem_read} !== 3'b000) begin errors++;
                $display("[TB] FAIL start_unhalted: busy/valid/rd=%b, need 000", {dbg_busy, dbg_valid, mem_read}); end
            @(posedge clk); #1;
        end
        collect_dump(1'b1, -1, 0, 1'b1, beats, cycles, bad, saw_done, w16);
        checks++;
        if (beats != 128 || bad != 0 || !saw_done) begin errors++;
            $display("[TB] FAIL start_busy: beats=%0d bad=%0d done=%b, need 128/0/1", beats, bad, saw_done); end
        @(posedge clk); #1;
        checks++;
        if (dbg_busy !== 1'b0) begin errors++; $display("[TB] FAIL start_busy_restart: busy=%b after done, need 0", dbg_busy); end
    endtask

    task automatic test_reset_mid_out();
        dbg_ready = 1'b0; dbg_halted = 1'b1; dbg_start = 1'b1;
        @(posedge clk); #1;
        dbg_start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dbg_valid !== 1'b1) begin errors++; $display("[TB] FAIL midout_valid: valid=%b, need 1", dbg_valid); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({dbg_valid, dbg_busy, dbg_done} !== 3'b000 || dbg_word !== 32'h0 || dbg_addr !== 9'h0)
            begin errors++; $display("[TB] FAIL midout_reset: valid/busy/done=%b word=%h addr=%h, need 000/0/0",
                                     {dbg_valid, dbg_busy, dbg_done}, dbg_word, dbg_addr); end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({dbg_done, dbg_busy} !== 2'b00) begin errors++;
                $display("[TB] FAIL midout_nodone: done/busy=%b, need 00", {dbg_done, dbg_busy}); end
        end
    endtask

    initial begin
        for (int i = 0; i < DUMP_WORDS; i++) begin
            mem[i] <= 32'hA500_0000 + 32'(i);
            expw[i] = 32'hA500_0000 + 32'(i);
        end
        reset = 1'b1;
        pipe_addr = '0; pipe_wdata = '0; pipe_read = 1'b0; pipe_write = 1'b0; pipe_bhw = 3'b000;
        dbg_start = 1'b0; dbg_halted = 1'b0; dbg_ready = 1'b0;
        test_reset();
        test_pipe_passthrough();
        test_full_dump();
        test_backpressure();
        test_conflict();
        test_ignored_start();
        test_reset_mid_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, need finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
